// File: rtl/pong_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl_if
// Bundles the signals exchanged between the Pong control FSM and its
// environment (player/ball events, datapath status and datapath controls).
//   master : the control FSM (consumes events/status, drives controls/status)
//   slave  : the datapath / game environment (the reverse direction)
// Signals:
//   Start, Hit, Miss        asynchronous level events
//   T5_out                  5 s timer expiry
//   Hit_out[7:0]            hit count from the datapath
//   Lvl_out[3:0]            level from the datapath (status only)
//   T5_en/T5_rst/T20_en/T20_rst, Hit_ld/Hit_clr/Lvl_clr   datapath controls
//   State_out[2:0], Lives_out[2:0], Game_over, Hit_drop, Hit_err  status
// -----------------------------------------------------------------------------
interface pong_game_ctrl_if;
   logic       Start;
   logic       Hit;
   logic       Miss;
   logic       T5_out;
   logic [7:0] Hit_out;
   logic [3:0] Lvl_out;
   logic       T5_en;
   logic       T5_rst;
   logic       T20_en;
   logic       T20_rst;
   logic       Hit_ld;
   logic       Hit_clr;
   logic       Lvl_clr;
   logic [2:0] State_out;
   logic [2:0] Lives_out;
   logic       Game_over;
   logic       Hit_drop;
   logic       Hit_err;

   modport master (
      input  Start, Hit, Miss, T5_out, Hit_out, Lvl_out,
      output T5_en, T5_rst, T20_en, T20_rst, Hit_ld, Hit_clr, Lvl_clr,
             State_out, Lives_out, Game_over, Hit_drop, Hit_err
   );

   modport slave (
      output Start, Hit, Miss, T5_out, Hit_out, Lvl_out,
      input  T5_en, T5_rst, T20_en, T20_rst, Hit_ld, Hit_clr, Lvl_clr,
             State_out, Lives_out, Game_over, Hit_drop, Hit_err
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
// Control FSM for the Pong datapath: idle, serve countdown, play, game over,
// plus a load handshake that holds Hit_ld until the slow-clock hit counter
// moves (or a timeout expires).
// Ports:
//   Clk  system clock
//   Rst  asynchronous active-low reset
//   bus  pong_game_ctrl_if.master (events, datapath status and controls)
// Parameters:
//   LIVES   misses allowed before game over (1..7)
//   HIT_TO  Clk cycles Hit_ld is held before the handshake is abandoned
//   TO_W    width of the handshake timeout counter
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
   parameter int LIVES  = 3,
   parameter int HIT_TO = 1000000,
   parameter int TO_W   = 20
) (
   input  logic             Clk,
   input  logic             Rst,
   pong_game_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_OVER  = 3'd3
   } state_t;

   typedef enum logic {
      H_IDLE = 1'b0,
      H_WAIT = 1'b1
   } hs_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(HIT_TO - 1);

   state_t          r_state;
   hs_t             r_hs;
   logic [2:0]      r_start_sy, r_hit_sy, r_miss_sy;
   logic            r_t5_en, r_t5_rst, r_t20_en, r_t20_rst;
   logic            r_hit_ld, r_hit_clr, r_lvl_clr;
   logic [2:0]      r_lives;
   logic            r_game_over, r_hit_drop, r_hit_err;
   logic [7:0]      r_snap;
   logic [TO_W-1:0] r_to_cnt;

   logic w_start_p, w_hit_p, w_miss_p;
   logic w_hit_take, w_hit_live, w_to_idle;
   logic w_unused_lvl;

   // Two synchronizer flops followed by an edge-detect flop.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_start_sy <= '0;
         r_hit_sy   <= '0;
         r_miss_sy  <= '0;
      end else begin
         r_start_sy <= {r_start_sy[1:0], bus.Start};
         r_hit_sy   <= {r_hit_sy[1:0],   bus.Hit};
         r_miss_sy  <= {r_miss_sy[1:0],  bus.Miss};
      end
   end

   assign w_start_p = r_start_sy[1] & ~r_start_sy[2];
   assign w_hit_p   = r_hit_sy[1]   & ~r_hit_sy[2];
   assign w_miss_p  = r_miss_sy[1]  & ~r_miss_sy[2];

   // A simultaneous miss in PLAY swallows the hit silently.
   assign w_hit_live = w_hit_p & ~(w_miss_p & (r_state == S_PLAY));
   assign w_hit_take = w_hit_live & (r_state == S_PLAY);
   assign w_to_idle  = (r_state == S_OVER) & w_start_p;

   assign w_unused_lvl = ^bus.Lvl_out;

   // Main game FSM; outputs are updated on the edge that enters each state.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state     <= S_IDLE;
         r_t5_en     <= 1'b0;
         r_t5_rst    <= 1'b1;
         r_t20_en    <= 1'b0;
         r_t20_rst   <= 1'b1;
         r_hit_clr   <= 1'b1;
         r_lvl_clr   <= 1'b1;
         r_lives     <= 3'(LIVES);
         r_game_over <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_p) begin
                  r_state   <= S_SERVE;
                  r_t5_rst  <= 1'b0;
                  r_t5_en   <= 1'b1;
                  r_t20_en  <= 1'b0;
                  r_t20_rst <= 1'b1;
                  r_hit_clr <= 1'b0;
                  r_lvl_clr <= 1'b0;
               end
            end
            S_SERVE: begin
               if (bus.T5_out) begin
                  r_state   <= S_PLAY;
                  r_t5_rst  <= 1'b1;   // restart the countdown for the next serve
                  r_t5_en   <= 1'b0;
                  r_t20_rst <= 1'b0;
                  r_t20_en  <= 1'b1;
               end
            end
            S_PLAY: begin
               r_t5_rst <= 1'b0;       // T5_rst is high only on the PLAY entry cycle
               if (w_miss_p) begin
                  r_t20_en <= 1'b0;
                  if (r_lives <= 3'd1) begin
                     r_state     <= S_OVER;
                     r_lives     <= '0;
                     r_game_over <= 1'b1;
                     r_t5_en     <= 1'b0;
                  end else begin
                     r_state   <= S_SERVE;
                     r_lives   <= r_lives - 3'd1;
                     r_t5_en   <= 1'b1;
                     r_t20_rst <= 1'b1;
                  end
               end
            end
            S_OVER: begin
               if (w_start_p) begin
                  r_state     <= S_IDLE;
                  r_t5_en     <= 1'b0;
                  r_t5_rst    <= 1'b1;
                  r_t20_en    <= 1'b0;
                  r_t20_rst   <= 1'b1;
                  r_hit_clr   <= 1'b1;
                  r_lvl_clr   <= 1'b1;
                  r_lives     <= 3'(LIVES);
                  r_game_over <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Hit load handshake: hold Hit_ld until the slow-domain count moves.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_hs       <= H_IDLE;
         r_hit_ld   <= 1'b0;
         r_snap     <= '0;
         r_to_cnt   <= '0;
         r_hit_drop <= 1'b0;
         r_hit_err  <= 1'b0;
      end else begin
         r_hit_drop <= 1'b0;
         r_hit_err  <= 1'b0;
         if (w_to_idle) begin
            r_hs     <= H_IDLE;
            r_hit_ld <= 1'b0;
         end else begin
            case (r_hs)
               H_IDLE: begin
                  if (w_hit_take && (bus.Hit_out != 8'hFF)) begin
                     r_snap   <= bus.Hit_out;
                     r_hit_ld <= 1'b1;
                     r_to_cnt <= '0;
                     r_hs     <= H_WAIT;
                  end
               end
               H_WAIT: begin
                  if (w_hit_live) r_hit_drop <= 1'b1;
                  if (bus.Hit_out != r_snap) begin
                     r_hit_ld <= 1'b0;
                     r_hs     <= H_IDLE;
                  end else if (r_to_cnt == TO_LAST) begin
                     r_hit_ld  <= 1'b0;
                     r_hit_err <= 1'b1;
                     r_hs      <= H_IDLE;
                  end else begin
                     r_to_cnt <= r_to_cnt + TO_W'(1);
                  end
               end
               default: r_hs <= H_IDLE;
            endcase
         end
      end
   end

   assign bus.T5_en     = r_t5_en;
   assign bus.T5_rst    = r_t5_rst;
   assign bus.T20_en    = r_t20_en;
   assign bus.T20_rst   = r_t20_rst;
   assign bus.Hit_ld    = r_hit_ld;
   assign bus.Hit_clr   = r_hit_clr;
   assign bus.Lvl_clr   = r_lvl_clr;
   assign bus.State_out = r_state;
   assign bus.Lives_out = r_lives;
   assign bus.Game_over = r_game_over;
   assign bus.Hit_drop  = r_hit_drop;
   assign bus.Hit_err   = r_hit_err;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
// Self-checking bench for pong_game_ctrl: directed timing sequences, a table
// of event vectors, and randomized events checked against an event-level
// model of the game rules. The bench also plays the datapath: it bumps the
// hit count some cycles after Hit_ld rises, or leaves it frozen.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;
   localparam int LIVES  = 3;
   localparam int HIT_TO = 16;

   localparam int EV_START   = 0;
   localparam int EV_T5      = 1;
   localparam int EV_MISS    = 2;
   localparam int EV_HIT     = 3;
   localparam int EV_HITMISS = 4;

   logic Clk = 1'b0;
   logic Rst = 1'b1;

   pong_game_ctrl_if bus();

   pong_game_ctrl #(.LIVES(LIVES), .HIT_TO(HIT_TO), .TO_W(20)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         n_err_seen = 0;
   int         n_drop_seen = 0;
   int         ld_age = 0;
   bit         ld_seen = 1'b0;
   bit         dp_respond = 1'b0;
   int         dp_delay = 1;
   logic [7:0] dp_cnt = 8'h00;

   assign bus.Hit_out = dp_cnt;
   assign bus.Lvl_out = 4'h3;

   typedef struct {
      int         ev;
      logic [7:0] val;
      bit         resp;
      int         dly;
      int         st;
      int         lives;
      int         go;
      int         cnt;
      int         errs;
      int         drops;
      bit         ld;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock: sample 1 time unit after the edge, then act as the datapath.
   task automatic tick();
      @(posedge Clk);
      #1;
      if (bus.Hit_err)  n_err_seen++;
      if (bus.Hit_drop) n_drop_seen++;
      if (bus.Hit_ld) begin
         ld_seen = 1'b1;
         ld_age++;
         if (dp_respond && ld_age == dp_delay) dp_cnt = dp_cnt + 8'd1;
      end else begin
         ld_age = 0;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      Rst = 1'b0;
      ticks(2);
      Rst = 1'b1;
      ticks(2);
   endtask

   task automatic run_event(input int ev, input logic [7:0] val, input bit resp, input int dly);
      dp_respond = resp;
      dp_delay   = dly;
      ld_seen    = 1'b0;
      if (ev == EV_HIT || ev == EV_HITMISS) dp_cnt = val;
      case (ev)
         EV_START:   bus.Start  = 1'b1;
         EV_T5:      bus.T5_out = 1'b1;
         EV_MISS:    bus.Miss   = 1'b1;
         EV_HIT:     bus.Hit    = 1'b1;
         default: begin
            bus.Hit  = 1'b1;
            bus.Miss = 1'b1;
         end
      endcase
      ticks(4);
      bus.Start  = 1'b0;
      bus.T5_out = 1'b0;
      bus.Miss   = 1'b0;
      bus.Hit    = 1'b0;
      ticks(24);
   endtask

   task automatic check_all(input string tag, input int st, input int lives, input int go,
                            input int cnt, input int errs, input int drops, input bit ld);
      chk({tag, " state"},     int'(bus.State_out), st);
      chk({tag, " lives"},     int'(bus.Lives_out), lives);
      chk({tag, " game_over"}, int'(bus.Game_over), go);
      chk({tag, " T5_en"},     int'(bus.T5_en),  (st == 1) ? 1 : 0);
      chk({tag, " T20_en"},    int'(bus.T20_en), (st == 2) ? 1 : 0);
      chk({tag, " Hit_clr"},   int'(bus.Hit_clr), (st == 0) ? 1 : 0);
      chk({tag, " Hit_ld"},    int'(bus.Hit_ld), 0);
      chk({tag, " hit_count"}, int'(dp_cnt), cnt);
      chk({tag, " err_pulses"},  n_err_seen, errs);
      chk({tag, " drop_pulses"}, n_drop_seen, drops);
      chk({tag, " ld_seen"},   int'(ld_seen), int'(ld));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int m_st, m_lives, m_cnt, m_err, ev, k, dly;
      bit m_ld, resp;
      logic [7:0] val;

      // {ev, val, resp, dly, state, lives, go, count, errs, drops, ld_seen}
      tbl[0]  = '{EV_START,   8'h00, 1'b0, 1,  1, 3, 0, 8'h00, 0, 0, 1'b0};
      tbl[1]  = '{EV_T5,      8'h00, 1'b0, 1,  2, 3, 0, 8'h00, 0, 0, 1'b0};
      tbl[2]  = '{EV_HIT,     8'h05, 1'b1, 3,  2, 3, 0, 8'h06, 0, 0, 1'b1};
      tbl[3]  = '{EV_HIT,     8'hFF, 1'b1, 3,  2, 3, 0, 8'hFF, 0, 0, 1'b0};
      tbl[4]  = '{EV_HIT,     8'h10, 1'b0, 1,  2, 3, 0, 8'h10, 1, 0, 1'b1};
      tbl[5]  = '{EV_MISS,    8'h00, 1'b0, 1,  1, 2, 0, 8'h10, 1, 0, 1'b0};
      tbl[6]  = '{EV_T5,      8'h00, 1'b0, 1,  2, 2, 0, 8'h10, 1, 0, 1'b0};
      tbl[7]  = '{EV_HITMISS, 8'h20, 1'b1, 2,  1, 1, 0, 8'h20, 1, 0, 1'b0};
      tbl[8]  = '{EV_T5,      8'h00, 1'b0, 1,  2, 1, 0, 8'h20, 1, 0, 1'b0};
      tbl[9]  = '{EV_HIT,     8'h30, 1'b1, 10, 2, 1, 0, 8'h31, 1, 0, 1'b1};
      tbl[10] = '{EV_MISS,    8'h00, 1'b0, 1,  3, 0, 1, 8'h31, 1, 0, 1'b0};
      tbl[11] = '{EV_START,   8'h00, 1'b0, 1,  0, 3, 0, 8'h31, 1, 0, 1'b0};
      tbl[12] = '{EV_START,   8'h00, 1'b0, 1,  1, 3, 0, 8'h31, 1, 0, 1'b0};
      tbl[13] = '{EV_T5,      8'h00, 1'b0, 1,  2, 3, 0, 8'h31, 1, 0, 1'b0};
      tbl[14] = '{EV_HIT,     8'h40, 1'b1, 1,  2, 3, 0, 8'h41, 1, 0, 1'b1};

      bus.Start = 1'b0; bus.Hit = 1'b0; bus.Miss = 1'b0; bus.T5_out = 1'b0;

      // Reset values
      #3 Rst = 1'b0;
      #1;
      chk("rst state",   int'(bus.State_out), 0);
      chk("rst Hit_clr", int'(bus.Hit_clr), 1);
      chk("rst Lvl_clr", int'(bus.Lvl_clr), 1);
      chk("rst T5_rst",  int'(bus.T5_rst), 1);
      chk("rst T20_rst", int'(bus.T20_rst), 1);
      chk("rst T5_en",   int'(bus.T5_en), 0);
      chk("rst T20_en",  int'(bus.T20_en), 0);
      chk("rst Hit_ld",  int'(bus.Hit_ld), 0);
      chk("rst lives",   int'(bus.Lives_out), LIVES);
      chk("rst game_over", int'(bus.Game_over), 0);
      ticks(2);
      Rst = 1'b1;
      ticks(2);

      // Start pulse lands on the third edge
      bus.Start = 1'b1;
      ticks(2);
      chk("start edge2 state", int'(bus.State_out), 0);
      tick();
      chk("start edge3 state", int'(bus.State_out), 1);
      chk("serve T5_en",   int'(bus.T5_en), 1);
      chk("serve T5_rst",  int'(bus.T5_rst), 0);
      chk("serve Hit_clr", int'(bus.Hit_clr), 0);
      chk("serve Lvl_clr", int'(bus.Lvl_clr), 0);
      bus.Start = 1'b0;
      ticks(3);

      // Countdown expiry: PLAY with a single-cycle T5_rst
      bus.T5_out = 1'b1;
      tick();
      chk("play state",   int'(bus.State_out), 2);
      chk("play T5_rst entry", int'(bus.T5_rst), 1);
      chk("play T20_en",  int'(bus.T20_en), 1);
      chk("play T20_rst", int'(bus.T20_rst), 0);
      chk("play T5_en",   int'(bus.T5_en), 0);
      bus.T5_out = 1'b0;
      tick();
      chk("play T5_rst after", int'(bus.T5_rst), 0);

      // Handshake held until the count moves, released on the next edge
      dp_respond = 1'b0;
      dp_cnt = 8'h05;
      bus.Hit = 1'b1;
      ticks(2);
      chk("hs ld before", int'(bus.Hit_ld), 0);
      tick();
      chk("hs ld on", int'(bus.Hit_ld), 1);
      bus.Hit = 1'b0;
      ticks(3);
      chk("hs ld hold", int'(bus.Hit_ld), 1);
      dp_cnt = 8'h06;
      tick();
      chk("hs ld off", int'(bus.Hit_ld), 0);
      ticks(20);

      // Second hit during H_WAIT is dropped with one pulse
      n_drop_seen = 0;
      n_err_seen  = 0;
      bus.Hit = 1'b1;
      ticks(3);
      chk("drop ld on", int'(bus.Hit_ld), 1);
      bus.Hit = 1'b0;
      ticks(2);
      bus.Hit = 1'b1;
      ticks(3);
      chk("drop pulse", int'(bus.Hit_drop), 1);
      bus.Hit = 1'b0;
      tick();
      chk("drop pulse width", int'(bus.Hit_drop), 0);
      dp_cnt = 8'h07;
      ticks(2);
      chk("drop ld off", int'(bus.Hit_ld), 0);
      ticks(20);
      chk("drop count", n_drop_seen, 1);
      chk("drop no err", n_err_seen, 0);
      chk("drop no relaunch", int'(bus.Hit_ld), 0);

      // Frozen count: Hit_ld held exactly HIT_TO cycles, then Hit_err
      dp_cnt = 8'h08;
      bus.Hit = 1'b1;
      ticks(3);
      bus.Hit = 1'b0;
      len = 0;
      for (int g = 0; g < 100; g++) begin
         if (!bus.Hit_ld) break;
         len++;
         tick();
      end
      chk("timeout ld length", len, HIT_TO);
      chk("timeout err pulse", int'(bus.Hit_err), 1);
      ticks(4);

      // Reset in PLAY with Hit_ld high
      bus.Hit = 1'b1;
      ticks(3);
      bus.Hit = 1'b0;
      chk("midrst ld before", int'(bus.Hit_ld), 1);
      ticks(2);
      Rst = 1'b0;
      #1;
      chk("midrst state",   int'(bus.State_out), 0);
      chk("midrst Hit_ld",  int'(bus.Hit_ld), 0);
      chk("midrst Hit_clr", int'(bus.Hit_clr), 1);
      chk("midrst lives",   int'(bus.Lives_out), LIVES);
      tick();
      Rst = 1'b1;
      ticks(2);

      // Vector table from a fresh reset
      do_reset();
      dp_cnt = 8'h00;
      n_err_seen = 0;
      n_drop_seen = 0;
      for (int i = 0; i < 15; i++) begin
         run_event(tbl[i].ev, tbl[i].val, tbl[i].resp, tbl[i].dly);
         check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].lives, tbl[i].go,
                   tbl[i].cnt, tbl[i].errs, tbl[i].drops, tbl[i].ld);
      end

      // Randomized events against the game-rule model
      do_reset();
      dp_cnt = 8'h00;
      n_err_seen = 0;
      n_drop_seen = 0;
      m_st = 0; m_lives = LIVES; m_cnt = 0; m_err = 0;
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 9);
         ev = (k < 2) ? EV_START : (k < 4) ? EV_T5 : (k < 6) ? EV_MISS :
              (k < 9) ? EV_HIT : EV_HITMISS;
         k    = $urandom_range(0, 4);
         val  = (k == 0) ? 8'hFF : 8'($urandom_range(0, 254));
         resp = (k >= 2);
         dly  = $urandom_range(1, 12);
         m_ld = 1'b0;
         case (ev)
            EV_START: begin
               if (m_st == 0) m_st = 1;
               else if (m_st == 3) begin m_st = 0; m_lives = LIVES; end
            end
            EV_T5: if (m_st == 1) m_st = 2;
            EV_HIT: begin
               m_cnt = val;
               if (m_st == 2 && val != 8'hFF) begin
                  m_ld = 1'b1;
                  if (resp) m_cnt = val + 1;
                  else m_err++;
               end
            end
            default: begin
               if (ev == EV_HITMISS) m_cnt = val;
               if (m_st == 2) begin
                  m_lives--;
                  m_st = (m_lives == 0) ? 3 : 1;
               end
            end
         endcase
         run_event(ev, val, resp, dly);
         check_all($sformatf("rnd%0d ev%0d", i, ev), m_st, m_lives, (m_st == 3) ? 1 : 0,
                   m_cnt, m_err, 0, m_ld);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Control FSM that drives the Pong datapath's control inputs: `T5_en`/`T5_rst`, `T20_en`/`T20_rst`, `Hit_ld`/`Hit_clr` and `Lvl_clr`.
- Consumes the datapath's status outputs (`T5_out`, `Hit_out`, `Lvl_out`) and the player/ball events `Start`, `Hit` and `Miss`.
- Sequences the game: idle, serve countdown, play, game over.
- Runs a load handshake so hits are counted in the datapath's slow `Clk_out` domain.

Parameters:
- `LIVES`, 3, misses allowed before game over (1..7).
- `HIT_TO`, 1000000, `Clk` cycles to hold `Hit_ld` before abandoning a handshake.
- `TO_W`, 20, width of the handshake timeout counter.

Ports:
- `Clk`  in  1  system clock.
- `Rst`  in  1  asynchronous, active-low reset (0 = reset).
- `Start`  in  1  start button; asynchronous, level.
- `Hit`  in  1  paddle-hit event from game logic; asynchronous, level.
- `Miss`  in  1  ball-missed event; asynchronous, level.
- `T5_out`  in  1  5 s timer expiry from the datapath.
- `Hit_out`  in  8  hit count from the datapath.
- `Lvl_out`  in  4  level from the datapath (status only).
- `T5_en`, `T5_rst`, `T20_en`, `T20_rst`  out  1 each  timer controls.
- `Hit_ld`, `Hit_clr`, `Lvl_clr`  out  1 each  counter controls.
- `State_out`  out  3  state code: IDLE=0, SERVE=1, PLAY=2, OVER=3.
- `Lives_out`  out  3  lives remaining.
- `Game_over`  out  1  high in OVER.
- `Hit_drop`  out  1  1-cycle pulse when a hit is discarded.
- `Hit_err`  out  1  1-cycle pulse on handshake timeout.

Behaviour:
- **Input conditioning**
  - `Start`, `Hit` and `Miss` each pass through a 2-flop synchronizer, then a rising-edge detector.
  - The internal pulse occurs 3 `Clk` edges after the input rises.
  - A level held high produces one pulse only.
- **Output timing**
  - All outputs are registered and reflect the current state.
  - Control outputs change on the `Clk` edge that enters a state.
- **Reset (`Rst`=0, asynchronous)**
  - State = IDLE.
  - `Hit_clr`=`Lvl_clr`=`T5_rst`=`T20_rst`=1.
  - `T5_en`=`T20_en`=`Hit_ld`=0.
  - `Lives_out`=`LIVES`, `Game_over`=0.
  - Handshake goes to H_IDLE.
  - Synchronizers are cleared.
- **IDLE**
  - Outputs: clears and resets asserted, enables low, `Lives_out` reloaded to `LIVES`.
  - Start pulse -> SERVE.
- **SERVE**
  - Outputs: `T5_rst`=0, `T5_en`=1, `T20_en`=0, all clears 0.
  - `T5_out`=1 -> PLAY. `T5_rst` pulses high for the single entry cycle of PLAY so the next countdown restarts from 0.
- **PLAY**
  - Outputs: `T20_rst`=0, `T20_en`=1, `T5_en`=0.
  - Miss pulse:
    - decrement Lives;
    - if Lives was 1 -> OVER (Lives=0);
    - else -> SERVE.
  - Hit pulse is forwarded to the handshake.
  - Hit and Miss pulses in the same cycle: Miss wins; the hit is discarded with no `Hit_drop`.
- **OVER**
  - Outputs: `Game_over`=1, all enables 0. `Hit_out`/`Lvl_out` are not cleared, so the score stays visible.
  - Start pulse -> IDLE.
- **Hit handshake** (independent sub-FSM; H_IDLE, H_WAIT)
  - In H_IDLE, a hit pulse while in PLAY:
    - if `Hit_out`==8'hFF: saturate, ignore, no pulse;
    - else: capture `Hit_out` into a snapshot, set `Hit_ld`=1, clear the timeout counter, go to H_WAIT.
  - H_WAIT exit conditions:
    - `Hit_out` != snapshot -> `Hit_ld`=0, H_IDLE on the next edge;
    - counter reaches `HIT_TO`-1 -> `Hit_ld`=0, `Hit_err` pulses, H_IDLE.
  - Hit pulse arriving in H_WAIT -> `Hit_drop` pulses; the hit is not queued.
  - Leaving PLAY (to SERVE/OVER) mid-handshake: the handshake completes normally.
  - Entering IDLE aborts it immediately: `Hit_ld`=0, H_IDLE.
- **Counter widths**
  - Lives is 3 bits; it never decrements below 0.
  - The timeout counter saturates at `HIT_TO`-1.
- **Reset mid-operation:** asynchronous return to reset values from any state or handshake phase.

Test Plan:
- **Reset to start:** `Rst`=0 in PLAY with `Hit_ld`=1 -> immediately IDLE, `Hit_ld`=0, `Hit_clr`=1, `Lives_out`=3. Release, pulse `Start` -> SERVE 3 cycles later, `T5_en`=1, clears=0.
- **Countdown and first hit:** in SERVE assert `T5_out` -> PLAY, `T20_en`=1, one-cycle `T5_rst`. Hit with `Hit_out`=8'h05 -> `Hit_ld`=1 until `Hit_out`=8'h06, then `Hit_ld`=0 the next cycle.
- **Hit during handshake:** second Hit during H_WAIT -> one `Hit_drop` pulse, count increments once. `Hit_out` frozen for `HIT_TO` (set to 16) cycles -> `Hit_err` pulse, `Hit_ld`=0.
- **Saturation:** `Hit_out`=8'hFF, Hit pulse -> `Hit_ld` stays 0.
- **Misses to game over:** three Miss pulses (`LIVES`=3) -> `Lives_out` 2, 1 then OVER with `Lives_out`=0, `Game_over`=1, `Hit_out` untouched. Start -> IDLE, `Lives_out`=3, clears asserted.
- **Simultaneous events:** Hit and Miss rising together -> Lives decrements, `Hit_ld` stays 0, no `Hit_drop`.
